fetch_stage: RTL and testbench

Instruction fetch stage directly downstream of the program counter block: takes `cur_pc`, issues instruction-memory reads, buffers returned instructions with their PCs, and presents them to decode over a valid/ready handshake. It drives `Stop_en` back to the PC so the PC advances only when a fetch is accepted. On a taken branch (`flush`, asserted with the PC's `PCsel`) it discards all stale in-flight work.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 92 +++++++++
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage.
package fetch_pkg;
  localparam int XLEN      = 32;
  localparam int BUF_DEPTH = 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    E_EMPTY = 2'd0,
    E_WAIT  = 2'd1,
    E_FULL  = 2'd2
  } entry_state_e;

  typedef struct packed {
    entry_state_e    state;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order ring of fetch slots. A slot is allocated (WAIT) when a
// read is accepted, filled (FULL) when its data returns, and freed on pop.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_i,
  input  logic [XLEN-1:0]  alloc_pc_i,
  input  logic             fill_i,
  input  logic [31:0]      fill_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] occ_o,
  output logic [CNT_W-1:0] nwait_o,
  output logic             head_full_o,
  output logic [XLEN-1:0]  head_pc_o,
  output logic [31:0]      head_instr_o
);

  fetch_entry_t [BUF_DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic                         fill_hit;
  logic [PTR_W-1:0]             fill_idx;

  assign head_full_o  = (ent_q[head_q].state == E_FULL);
  assign head_pc_o    = ent_q[head_q].pc;
  assign head_instr_o = ent_q[head_q].instr;

  // Responses return in order, so the first WAIT slot walking from head is the one being answered.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = head_q;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      if (!fill_hit && ent_q[head_q + PTR_W'(k)].state == E_WAIT) begin
        fill_hit = 1'b1;
        fill_idx = head_q + PTR_W'(k);
      end
    end
  end

  // Occupancy and outstanding-read counts for the issue and drop logic.
  always_comb begin
    occ_o   = '0;
    nwait_o = '0;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      if (ent_q[k].state != E_EMPTY) occ_o   = occ_o + CNT_W'(1);
      if (ent_q[k].state == E_WAIT)  nwait_o = nwait_o + CNT_W'(1);
    end
  end

  // Slot updates: pop frees head, fill completes a WAIT slot, alloc claims tail.
  // Alloc is applied last so a slot freed by pop can be reused in the same cycle.
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      for (int k = 0; k < BUF_DEPTH; k++) ent_d[k].state = E_EMPTY;
      head_d = '0;
      tail_d = '0;
    end else begin
      if (pop_i) begin
        ent_d[head_q].state = E_EMPTY;
        head_d              = head_q + PTR_W'(1);
      end
      if (fill_i && fill_hit) begin
        ent_d[fill_idx].state = E_FULL;
        ent_d[fill_idx].instr = fill_data_i;
      end
      if (alloc_i) begin
        ent_d[tail_q].state = E_WAIT;
        ent_d[tail_q].pc    = alloc_pc_i;
        tail_d              = tail_q + PTR_W'(1);
      end
    end
  end

  // Ring state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues reads at cur_pc, buffers returned words with
// their PCs, hands them to decode, and discards reads orphaned by a redirect.
module fetch_stage
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] cur_pc,
  output logic            Stop_en,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  input  logic            id_ready
);

  logic [CNT_W-1:0] occ, nwait, drop_q, drop_d;
  logic             head_full, pop, accept, fill;
  logic [CNT_W:0]   inflight;

  // Decode never sees an instruction in the redirect cycle.
  assign id_valid = head_full & ~flush;
  assign pop      = id_valid & id_ready;

  // Slots that stay committed past this edge: live entries not leaving plus
  // reads still owed to us that will be thrown away.
  assign inflight       = {1'b0, occ} + {1'b0, drop_q} - {{CNT_W{1'b0}}, pop};
  assign imem_req_valid = rst & ~flush & (inflight < (CNT_W+1)'(BUF_DEPTH));
  assign imem_req_addr  = cur_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  // PC holds unless a fetch is taken; during a redirect it must load the target.
  assign Stop_en = ~rst | (~flush & ~accept);

  // Responses owed to a squashed fetch never reach the buffer.
  assign fill = imem_rsp_valid & ~flush & (drop_q == '0);

  // Drop counter: on redirect every WAIT slot becomes a read to discard, less
  // one if its response lands in the redirect cycle itself.
  always_comb begin
    drop_d = drop_q;
    if (flush) begin
      drop_d = CNT_W'({1'b0, drop_q} + {1'b0, nwait} - {{CNT_W{1'b0}}, imem_rsp_valid});
    end else if (imem_rsp_valid && drop_q != '0) begin
      drop_d = drop_q - CNT_W'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  fetch_buffer u_buf (
    .clk          (clk),
    .rst          (rst),
    .alloc_i      (accept),
    .alloc_pc_i   (cur_pc),
    .fill_i       (fill),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop),
    .flush_i      (flush),
    .occ_o        (occ),
    .nwait_o      (nwait),
    .head_full_o  (head_full),
    .head_pc_o    (id_pc),
    .head_instr_o (id_instr)
  );

  a_no_overcommit: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, occ} + {1'b0, drop_q}) <= (CNT_W+1)'(BUF_DEPTH));

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
    (imem_rsp_valid && !flush && drop_q == '0) |-> (nwait != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order memory with configurable latency, a PC
// that advances unless held, and a queue-level model of what decode must see.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cur_pc = '0;
  logic        Stop_en;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic        id_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .cur_pc(cur_pc), .Stop_en(Stop_en), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .id_ready(id_ready)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000 ^ {a[15:0], a[31:16]};
  endfunction

  // Reference model: fetches in order, each either waiting or arrived, plus
  // a count of responses to swallow.
  logic [31:0] m_pc[$];
  bit          m_arr[$];
  int          m_drop = 0;

  typedef struct { logic [31:0] data; int due; } rsp_t;
  rsp_t        memq[$];
  int          last_due = 0;
  int          cyc = 0;
  int          L = 1;
  int          acc_cnt = 0;
  logic [31:0] br_target = '0;
  logic [31:0] pc_next = '0;
  logic [31:0] dlv[$];
  int          dlv_cyc[$];

  event pre_ev;
  always @(negedge clk) begin
    #4;
    ->pre_ev;
  end

  task automatic mem_drive();
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Compare DUT against the model just before the edge, then advance both the
  // environment (memory, PC) and the model across that edge.
  task automatic eval_cycle();
    bit e_idv, e_pop, e_rv, e_stop, done;
    int nw, d;
    e_idv  = rst && !flush && m_pc.size() > 0 && m_arr[0];
    e_pop  = e_idv && id_ready;
    e_rv   = rst && !flush && (m_pc.size() - int'(e_pop) + m_drop < 2);
    e_stop = !rst || (!flush && !(e_rv && imem_req_ready));
    chkb("id_valid", id_valid, e_idv);
    chkb("imem_req_valid", imem_req_valid, e_rv);
    chkb("Stop_en", Stop_en, e_stop);
    if (e_idv) begin
      chk("id_pc", id_pc, m_pc[0]);
      chk("id_instr", id_instr, memfn(m_pc[0]));
    end
    if (e_rv) chk("imem_req_addr", imem_req_addr, cur_pc);
    chkb("outstanding_le2", memq.size() <= 2, 1'b1);

    if (rst && id_valid && id_ready) begin
      dlv.push_back(id_pc);
      dlv_cyc.push_back(cyc);
    end
    if (!rst)          pc_next = cur_pc;
    else if (flush)    pc_next = br_target;
    else if (!Stop_en) pc_next = cur_pc + 32'd4;
    else               pc_next = cur_pc;

    if (imem_rsp_valid) void'(memq.pop_front());
    if (rst && imem_req_valid && imem_req_ready) begin
      d = (cyc + L > last_due + 1) ? cyc + L : last_due + 1;
      memq.push_back('{memfn(imem_req_addr), d});
      last_due = d;
      acc_cnt++;
    end

    if (!rst) begin
      m_pc.delete(); m_arr.delete(); m_drop = 0;
    end else if (flush) begin
      nw = 0;
      foreach (m_arr[i]) if (!m_arr[i]) nw++;
      m_drop = m_drop + nw - int'(imem_rsp_valid);
      m_pc.delete(); m_arr.delete();
    end else begin
      if (imem_rsp_valid) begin
        if (m_drop > 0) m_drop--;
        else begin
          done = 1'b0;
          foreach (m_arr[i]) if (!done && !m_arr[i]) begin m_arr[i] = 1'b1; done = 1'b1; end
        end
      end
      if (e_pop) begin void'(m_pc.pop_front()); void'(m_arr.pop_front()); end
      if (e_rv && imem_req_ready) begin m_pc.push_back(cur_pc); m_arr.push_back(1'b0); end
    end
  endtask

  task automatic tick();
    @(pre_ev);
    eval_cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    cur_pc = pc_next;
    mem_drive();
  endtask

  // Asserts reset at a falling edge, checks it took effect at once, and
  // releases it one cycle later with the PC at pc0. Memory resets too.
  task automatic do_reset(input logic [31:0] pc0);
    rst = 1'b0;
    flush = 1'b0;
    #1;
    chkb("rst_id_valid", id_valid, 1'b0);
    chkb("rst_req_valid", imem_req_valid, 1'b0);
    chkb("rst_stop_en", Stop_en, 1'b1);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    memq.delete(); m_pc.delete(); m_arr.delete();
    m_drop = 0;
    @(posedge clk);
    cyc++;
    last_due = cyc;
    @(negedge clk);
    cur_pc = pc0;
    rst = 1'b1;
    mem_drive();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] p;
    @(negedge clk);

    // Reset and release
    imem_req_ready = 1'b1;
    id_ready = 1'b0;
    do_reset(32'd0);
    #1;
    chk("release_addr", imem_req_addr, 32'd0);
    chkb("release_req_valid", imem_req_valid, 1'b1);
    chkb("release_stop_en", Stop_en, 1'b0);

    // Streaming at L=1: one instruction per cycle
    id_ready = 1'b1;
    dlv.delete(); dlv_cyc.delete();
    repeat (7) tick();
    for (int i = 0; i < 4; i++) begin
      chk("stream_pc", (i < dlv.size()) ? dlv[i] : 32'hDEADBEEF, 32'(4 * i));
      chk("stream_gap", (i < dlv.size()) ? 32'(dlv_cyc[i] - dlv_cyc[0]) : 32'hDEADBEEF, 32'(i));
    end

    // Backpressure: two fetches fill the ring, PC parks at 8
    id_ready = 1'b0;
    do_reset(32'd0);
    acc_cnt = 0;
    repeat (5) tick();
    #1;
    chk("bp_accepts", 32'(acc_cnt), 32'd2);
    chk("bp_cur_pc", cur_pc, 32'd8);
    chkb("bp_stop_en", Stop_en, 1'b1);
    chkb("bp_req_valid", imem_req_valid, 1'b0);
    id_ready = 1'b1;
    dlv.delete(); dlv_cyc.delete();
    repeat (6) tick();
    for (int i = 0; i < 3; i++)
      chk("bp_order", (i < dlv.size()) ? dlv[i] : 32'hDEADBEEF, 32'(4 * i));

    // Memory stall: PC held, fetch resumes at the same address
    imem_req_ready = 1'b0;
    p = cur_pc;
    repeat (3) tick();
    #1;
    chk("stall_pc_held", cur_pc, p);
    chkb("stall_stop_en", Stop_en, 1'b1);
    imem_req_ready = 1'b1;
    #1;
    chkb("stall_resume_valid", imem_req_valid, 1'b1);
    chk("stall_resume_addr", imem_req_addr, p);
    tick();

    // Redirect with two reads outstanding (slow memory, L=3)
    L = 3;
    id_ready = 1'b1;
    do_reset(32'd0);
    repeat (6) tick();
    chk("fl2_model_size", 32'(m_pc.size()), 32'd2);
    chk("fl2_model_pc0", (m_pc.size() > 0) ? m_pc[0] : 32'hDEADBEEF, 32'd8);
    chk("fl2_model_pc1", (m_pc.size() > 1) ? m_pc[1] : 32'hDEADBEEF, 32'd12);
    chkb("fl2_no_rsp", imem_rsp_valid, 1'b0);
    flush = 1'b1;
    br_target = 32'd100;
    tick();
    flush = 1'b0;
    chk("fl2_drop_after", 32'(m_drop), 32'd2);
    chk("fl2_pc_redirect", cur_pc, 32'd100);
    dlv.delete(); dlv_cyc.delete();
    for (int i = 0; i < 30 && dlv.size() == 0; i++) tick();
    chk("fl2_drop_drained", 32'(m_drop), 32'd0);
    chk("fl2_first_pc", (dlv.size() > 0) ? dlv[0] : 32'hDEADBEEF, 32'd100);

    // Redirect while a response lands: one FULL, one WAIT
    L = 1;
    id_ready = 1'b0;
    do_reset(32'd0);
    repeat (2) tick();
    chk("fl1_model_size", 32'(m_pc.size()), 32'd2);
    chkb("fl1_head_arrived", (m_arr.size() > 0) ? m_arr[0] : 1'b0, 1'b1);
    chkb("fl1_rsp_now", imem_rsp_valid, 1'b1);
    flush = 1'b1;
    br_target = 32'd200;
    tick();
    flush = 1'b0;
    chk("fl1_drop_after", 32'(m_drop), 32'd0);
    id_ready = 1'b1;
    #1;
    chkb("fl1_req_valid", imem_req_valid, 1'b1);
    chk("fl1_req_addr", imem_req_addr, 32'd200);
    dlv.delete(); dlv_cyc.delete();
    for (int i = 0; i < 20 && dlv.size() == 0; i++) tick();
    chk("fl1_first_pc", (dlv.size() > 0) ? dlv[0] : 32'hDEADBEEF, 32'd200);

    // Randomised traffic with redirects, stalls, backpressure and resets
    for (int i = 0; i < 3000; i++) begin
      id_ready       = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      L              = $urandom_range(1, 3);
      flush          = ($urandom_range(0, 24) == 0);
      br_target      = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 299) == 0) do_reset(32'($urandom_range(0, 255)) << 2);
      else tick();
    end
    flush = 1'b0;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
